// File: rtl/sparse_varray_pkg.sv
// Shared constants, entry type and run-end arithmetic for the sparse virtual array.
package sparse_varray_pkg;

  localparam int ELEM_W_DEF    = 18;
  localparam int ADDR_W_DEF    = 16;
  localparam int LOG_DEPTH_DEF = 6;
  localparam int LEN_W_DEF     = 4;
  localparam int CALC_W        = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] start;
    logic [LEN_W_DEF-1:0]  len;
    logic [ELEM_W_DEF-1:0] data;
  } varray_entry_t;

  // One bit wider than the operands so an end address at the top of the space is not lost.
  function automatic logic [CALC_W:0] run_end(input logic [CALC_W-1:0] start,
                                              input logic [CALC_W-1:0] len);
    return {1'b0, start} + {1'b0, len};
  endfunction

endpackage

// File: rtl/sparse_varray_mem.sv
// Entry storage: one synchronous write port at head, one asynchronous read port at tail.
module sparse_varray_mem
  import sparse_varray_pkg::*;
#(
  parameter int WIDTH     = ADDR_W_DEF + LEN_W_DEF + ELEM_W_DEF,
  parameter int LOG_DEPTH = LOG_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LOG_DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [LOG_DEPTH-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [1 << LOG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sparse_varray.sv
// Sparse virtual array backed by a queue of run-length entries.
// Optional macro SPARSE_VARRAY_BYPASS_EN forwards an incoming run to a read on an empty queue.
module sparse_varray
  import sparse_varray_pkg::*;
#(
  parameter int ELEM_W    = ELEM_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LOG_DEPTH = LOG_DEPTH_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    write_addr,
  input  logic [LEN_W-1:0]     write_len,
  input  logic [ELEM_W-1:0]    dat_w,
  output logic                 write_ready,
  input  logic                 re,
  input  logic [ADDR_W-1:0]    read_addr,
  output logic [ELEM_W-1:0]    dat_r,
  output logic                 dat_r_valid,
  output logic [ADDR_W:0]      varray_len,
  output logic [LOG_DEPTH:0]   count,
  output logic                 overflow_err,
  output logic                 order_err,
  output logic                 miss_err
);

  localparam int DEPTH   = 1 << LOG_DEPTH;
  localparam int ENTRY_W = ADDR_W + LEN_W + ELEM_W;
  localparam logic [LOG_DEPTH:0] FULL_CNT = (LOG_DEPTH+1)'(DEPTH);

  // Same layout as varray_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0] start;
    logic [LEN_W-1:0]  len;
    logic [ELEM_W-1:0] data;
  } entry_t;

  logic [LOG_DEPTH-1:0] head, tail;
  logic [ENTRY_W-1:0]   tail_raw;
  entry_t               tail_ent, wr_ent, rd_ent;
  logic                 empty, len_ok, in_order, accept;
  logic                 ent_valid, hit, past, pop;
  logic [ADDR_W:0]      wr_end, rd_end, rd_next;

  assign write_ready = count < FULL_CNT;
  assign empty       = count == '0;
  assign len_ok      = write_len != '0;
  assign in_order    = {1'b0, write_addr} >= varray_len;
  assign accept      = we && write_ready && len_ok && in_order;
  assign wr_end      = (ADDR_W+1)'(run_end(CALC_W'(write_addr), CALC_W'(write_len)));
  assign wr_ent      = '{start: write_addr, len: write_len, data: dat_w};
  assign tail_ent    = tail_raw;

  sparse_varray_mem #(
    .WIDTH     (ENTRY_W),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (head),
    .wdata (wr_ent),
    .raddr (tail),
    .rdata (tail_raw)
  );

`ifdef SPARSE_VARRAY_BYPASS_EN
  always_comb begin
    rd_ent    = tail_ent;
    ent_valid = !empty;
    if (empty && accept) begin
      rd_ent    = wr_ent;
      ent_valid = 1'b1;
    end
  end
`else
  always_comb begin
    rd_ent    = tail_ent;
    ent_valid = !empty;
  end
`endif

  assign rd_end  = (ADDR_W+1)'(run_end(CALC_W'(rd_ent.start), CALC_W'(rd_ent.len)));
  assign rd_next = (ADDR_W+1)'(run_end(CALC_W'(read_addr), CALC_W'(1)));
  assign hit     = ent_valid && (read_addr >= rd_ent.start) && ({1'b0, read_addr} < rd_end);
  assign past    = ent_valid && ({1'b0, read_addr} >= rd_end);
  // A bypassed entry that is consumed the same cycle still moves head and tail together.
  assign pop     = re && (past || (hit && (rd_next == rd_end)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      varray_len   <= '0;
      dat_r        <= '0;
      dat_r_valid  <= 1'b0;
      overflow_err <= 1'b0;
      order_err    <= 1'b0;
      miss_err     <= 1'b0;
    end else begin
      if (accept) begin
        head       <= head + LOG_DEPTH'(1);
        varray_len <= wr_end;
      end
      if (pop) tail <= tail + LOG_DEPTH'(1);
      if (accept && !pop)      count <= count + (LOG_DEPTH+1)'(1);
      else if (pop && !accept) count <= count - (LOG_DEPTH+1)'(1);
      dat_r_valid <= re;
      if (re) dat_r <= hit ? rd_ent.data : '0;
      if (we && len_ok && !write_ready) overflow_err <= 1'b1;
      if (we && len_ok && !in_order)    order_err    <= 1'b1;
      if (re && past)                   miss_err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sparse_varray.sv
// Scoreboard bench for sparse_varray: directed scenarios plus random monotonic traffic
// checked against a run-queue model of the virtual array.
module tb_sparse_varray;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [15:0] write_addr = '0;
  logic [3:0]  write_len = '0;
  logic [17:0] dat_w = '0;
  logic        write_ready;
  logic        re = 1'b0;
  logic [15:0] read_addr = '0;
  logic [17:0] dat_r;
  logic        dat_r_valid;
  logic [16:0] varray_len;
  logic [6:0]  count;
  logic        overflow_err, order_err, miss_err;

  sparse_varray dut (
    .clk(clk), .reset(reset), .we(we), .write_addr(write_addr), .write_len(write_len),
    .dat_w(dat_w), .write_ready(write_ready), .re(re), .read_addr(read_addr),
    .dat_r(dat_r), .dat_r_valid(dat_r_valid), .varray_len(varray_len), .count(count),
    .overflow_err(overflow_err), .order_err(order_err), .miss_err(miss_err)
  );

  always #5 clk = ~clk;

  typedef struct { int start; int len; int data; } run_t;
  typedef struct { int cnt; int vlen; bit ovf; bit ord; bit miss; bit valid; int dat; } snap_t;

  run_t  mq[$];
  int    rd_q[$];
  snap_t st_q[$];
  int    m_vlen, m_dat;
  bit    m_ovf, m_ord, m_miss;
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); rd_q.delete(); st_q.delete();
    m_vlen = 0; m_dat = 0; m_ovf = 0; m_ord = 0; m_miss = 0;
  endtask

  function automatic snap_t snap(input bit valid);
    snap_t s;
    s.cnt = mq.size(); s.vlen = m_vlen; s.ovf = m_ovf; s.ord = m_ord;
    s.miss = m_miss; s.valid = valid; s.dat = m_dat;
    return s;
  endfunction

  // One clock of stimulus; the model applies the array's rules to the request.
  task automatic cycle(input bit w, input int wa, input int wl, input int dw,
                       input bit r, input int ra);
    bit   acc, have, popit, consumed;
    run_t t;
    int   rd;
    @(negedge clk);
    we = w; write_addr = 16'(wa); write_len = 4'(wl); dat_w = 18'(dw);
    re = r; read_addr = 16'(ra);
    acc = w && wl != 0 && mq.size() < 64 && wa >= m_vlen;
    if (w && wl != 0 && mq.size() >= 64) m_ovf = 1;
    if (w && wl != 0 && wa < m_vlen) m_ord = 1;
    consumed = 0;
    if (r) begin
      have = 0; popit = 0; rd = 0;
      if (mq.size() > 0) begin t = mq[0]; have = 1; end
`ifdef SPARSE_VARRAY_BYPASS_EN
      else if (acc) begin t = '{wa, wl, dw}; have = 1; end
`endif
      if (have) begin
        if (ra >= t.start && ra < t.start + t.len) begin
          rd = t.data;
          popit = (ra + 1 == t.start + t.len);
        end else if (ra >= t.start + t.len) begin
          popit = 1; m_miss = 1;
        end
      end
      if (popit) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else consumed = 1;
      end
      m_dat = rd;
      rd_q.push_back(rd);
    end
    if (acc) begin
      if (!consumed) mq.push_back('{wa, wl, dw});
      m_vlen = wa + wl;
    end
    st_q.push_back(snap(r));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_ready"}, 32'(write_ready), 1);
    chk({tag, "_vlen"}, 32'(varray_len), 0);
    chk({tag, "_dat_r"}, 32'(dat_r), 0);
    chk({tag, "_valid"}, 32'(dat_r_valid), 0);
    chk({tag, "_errs"}, 32'({overflow_err, order_err, miss_err}), 0);
  endtask

  // Reset is raised between clock edges and the outputs are checked before any edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    we = 0; re = 0;
    #2 reset = 1;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    reset = 0;
    model_reset();
    st_q.push_back(snap(0));
  endtask

  // Monitor: one expected snapshot per clock, read data popped when dat_r_valid is seen.
  initial begin
    snap_t s;
    int    e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("count", 32'(count), s.cnt);
        chk("write_ready", 32'(write_ready), (s.cnt < 64) ? 1 : 0);
        chk("varray_len", 32'(varray_len), s.vlen);
        chk("overflow_err", 32'(overflow_err), s.ovf);
        chk("order_err", 32'(order_err), s.ord);
        chk("miss_err", 32'(miss_err), s.miss);
        chk("dat_r_valid", 32'(dat_r_valid), s.valid);
        chk("dat_r_held", 32'(dat_r), s.dat);
        if (dat_r_valid) begin
          if (rd_q.size() == 0) chk("rd_q_nonempty", 0, 1);
          else begin
            e = rd_q.pop_front();
            chk("read_data", 32'(dat_r), e);
          end
        end
      end
    end
  end

  initial begin
    int rcur, wa, wl, r;
    model_reset();
    do_reset("reset0");

    // Single run read across its boundaries.
    cycle(1, 4, 3, 'h155, 0, 0);
    for (int a = 0; a < 8; a++) cycle(0, 0, 0, 0, 1, a);
    cycle(0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("run_vlen", 32'(varray_len), 7);
    chk("run_count", 32'(count), 0);

    // Fill to full, overflow, then one pop re-opens the queue.
    do_reset("reset1");
    for (int i = 0; i < 64; i++) cycle(1, i, 1, i + 100, 0, 0);
    cycle(1, 64, 1, 7, 0, 0);
    @(posedge clk); #2;
    chk("full_ready", 32'(write_ready), 0);
    chk("full_vlen", 32'(varray_len), 64);
    chk("full_ovf", 32'(overflow_err), 1);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Out-of-order write.
    do_reset("reset2");
    cycle(1, 10, 2, 9, 0, 0);
    cycle(1, 5, 1, 9, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("order_flag", 32'(order_err), 1);
    chk("order_count", 32'(count), 1);

    // Read that skips a queued run.
    do_reset("reset3");
    cycle(1, 0, 2, 'h11, 0, 0);
    cycle(1, 8, 2, 'h22, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 9);
    cycle(0, 0, 0, 0, 0, 0);

    // Read and write of the same single-element run on an empty queue.
    do_reset("reset4");
    cycle(1, 0, 1, 3, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Reset mid-stream with five entries queued.
    do_reset("reset5");
    for (int i = 0; i < 5; i++) cycle(1, 2 * i, 2, i + 1, 0, 0);
    do_reset("reset_mid");

    // Random monotonic traffic with occasional illegal writes and skipped reads.
    rcur = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_vlen > 60000) begin do_reset("reset_rand"); rcur = 0; end
      wa = 0; wl = 0;
      r = $urandom_range(0, 15);
      if (r == 0) wl = 0; else wl = $urandom_range(1, 15);
      if (r == 1 && m_vlen > 0) wa = m_vlen - 1 - $urandom_range(0, (m_vlen > 4) ? 3 : m_vlen - 1);
      else wa = m_vlen + $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0 && rcur < m_vlen) begin
        cycle($urandom_range(0, 2) == 0, wa, wl, $urandom_range(0, 'h3ffff), 1, rcur);
        rcur += ($urandom_range(0, 29) == 0) ? 20 : $urandom_range(0, 3);
      end else begin
        cycle($urandom_range(0, 1), wa, wl, $urandom_range(0, 'h3ffff), 0, 0);
      end
    end
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    @(posedge clk); #3;
    chk("rd_q_drained", 32'(rd_q.size()), 0);
    chk("st_q_drained", 32'(st_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
